permutation_engine: RTL and testbench

//  Parametrised, self-sequencing iterative permutation core. It generalises the 25-bit single-lane datapath
//  to a 5x5 array of LANE_W-bit lanes, with a configurable round count. Valid/ready handshakes are provided on

---
 rtl/permutation_engine.sv | 90 +++++++++
 tb/tb_permutation_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/permutation_engine.sv
// permutation_engine: iterative Keccak-style permutation of a 5x5 array of LANE_W-bit lanes,
// one round per clock, with valid/ready on both sides and an internal round sequencer.
module permutation_engine #(
  parameter int LANE_W = 1,
  parameter int ROUNDS = 24,
  parameter int CNT_W = 8,
  localparam int SW = 25 * LANE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SW-1:0]    out_data,
  output logic             busy,
  output logic [CNT_W-1:0] round_idx
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  // rotation offsets indexed [x][y]
  localparam int RHO [5][5] = '{
    '{ 0, 36,  3, 41, 18},
    '{ 1, 44, 10, 45,  2},
    '{62,  6, 43, 15, 61},
    '{28, 55, 25, 21, 56},
    '{27, 20, 39,  8, 14}
  };
  fsm_t fsm;
  logic [SW-1:0] state;
  logic [SW-1:0] nxt;
  logic last;
  function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v, input int n);
    int k;
    k = n % LANE_W;
    return (v << k) | (v >> (LANE_W - k));
  endfunction
  function automatic logic [SW-1:0] round_fn(input logic [SW-1:0] s, input logic [CNT_W-1:0] r);
    logic [LANE_W-1:0] a [5][5];
    logic [LANE_W-1:0] b [5][5];
    logic [LANE_W-1:0] c [5];
    logic [LANE_W-1:0] d [5];
    logic [SW-1:0] o;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        a[x][y] = s[(5*y+x)*LANE_W +: LANE_W];
    for (int x = 0; x < 5; x++)
      c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
    for (int x = 0; x < 5; x++)
      d[x] = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        b[y][(2*x+3*y)%5] = rotl(a[x][y] ^ d[x], RHO[x][y]);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        o[(5*y+x)*LANE_W +: LANE_W] = b[x][y] ^ (~b[(x+1)%5][y] & b[(x+2)%5][y]);
    // round constant is the round index itself, fitted to the lane width
    for (int i = 0; i < LANE_W && i < CNT_W; i++)
      o[i] = o[i] ^ r[i];
    return o;
  endfunction
  assign nxt = round_fn(state, round_idx);
  assign last = round_idx == CNT_W'(ROUNDS - 1);
  assign in_ready = fsm == IDLE || (fsm == DONE && out_ready);
  assign out_data = state;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm <= IDLE;
      state <= '0;
      round_idx <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else if (fsm == RUN) begin
      state <= nxt;
      round_idx <= last ? '0 : round_idx + 1'b1;
      fsm <= last ? DONE : RUN;
      busy <= !last;
      out_valid <= last;
    end else if (in_valid && in_ready) begin
      state <= in_data;
      round_idx <= '0;
      fsm <= RUN;
      busy <= 1'b1;
      out_valid <= 1'b0;
    end else if (fsm == DONE && out_ready) begin
      fsm <= IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_permutation_engine.sv
// tb_permutation_engine: vector table on two 1-bit-lane engines plus randomized 64-bit-lane
// traffic checked against a flat lane-array model of the permutation.
module tb_permutation_engine;
  localparam int W = 64, R = 24, SW = 25 * W;
  typedef struct {
    int          sel;
    logic [24:0] din;
    logic [24:0] exp;
  } vec_t;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
  logic [SW-1:0] in_data = '0, out_data;
  logic [7:0] round_idx;
  logic s_in_valid [2];
  logic s_in_ready [2];
  logic s_out_valid [2];
  logic s_out_ready [2];
  logic s_busy [2];
  logic [24:0] s_in_data [2];
  logic [24:0] s_out_data [2];
  logic [7:0] s_round_idx [2];
  int checks = 0, errors = 0;
  longint cyc = 0;
  int rho_off [25];

  permutation_engine #(.LANE_W(W), .ROUNDS(R), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .round_idx(round_idx));

  for (genvar g = 0; g < 2; g++) begin : g_small
    permutation_engine #(.LANE_W(1), .ROUNDS(g + 1), .CNT_W(8)) u_small (
      .clk(clk), .rst(rst), .in_valid(s_in_valid[g]), .in_ready(s_in_ready[g]),
      .in_data(s_in_data[g]), .out_valid(s_out_valid[g]), .out_ready(s_out_ready[g]),
      .out_data(s_out_data[g]), .busy(s_busy[g]), .round_idx(s_round_idx[g]));
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_blk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < 25; i++)
        if (act[i*W +: W] !== exp[i*W +: W]) begin
          $display("FAIL %s: lane %0d got %016h expected %016h (cycle %0d)", name, i,
                   act[i*W +: W], exp[i*W +: W], cyc);
          break;
        end
    end
  endtask

  function automatic logic [63:0] rot(input logic [63:0] v, input int n, input int w);
    logic [63:0] m;
    int k;
    m = (w == 64) ? '1 : ((64'd1 << w) - 1);
    k = n % w;
    return (k == 0) ? v : (((v << k) | (v >> (w - k))) & m);
  endfunction

  // Lanes kept in a flat array indexed 5*y+x; w-bit lanes held in 64-bit words.
  function automatic logic [SW-1:0] model(input logic [SW-1:0] s, input int w, input int rounds);
    logic [63:0] a [25];
    logic [63:0] b [25];
    logic [63:0] c [5];
    logic [63:0] d [5];
    logic [63:0] m;
    logic [SW-1:0] t, o;
    int x, y;
    m = (w == 64) ? '1 : ((64'd1 << w) - 1);
    for (int i = 0; i < 25; i++) begin
      t = s >> (i * w);
      a[i] = t[63:0] & m;
    end
    for (int r = 0; r < rounds; r++) begin
      for (int i = 0; i < 5; i++) c[i] = a[i] ^ a[i+5] ^ a[i+10] ^ a[i+15] ^ a[i+20];
      for (int i = 0; i < 5; i++) d[i] = c[(i+4)%5] ^ rot(c[(i+1)%5], 1, w);
      for (int i = 0; i < 25; i++) begin
        x = i % 5;
        y = i / 5;
        b[y + 5*((2*x + 3*y) % 5)] = rot(a[i] ^ d[x], rho_off[i], w);
      end
      for (int i = 0; i < 25; i++) begin
        x = i % 5;
        y = i / 5;
        a[i] = (b[i] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y])) & m;
      end
      a[0] = a[0] ^ (64'(r) & m);
    end
    o = '0;
    for (int i = 0; i < 25; i++) begin
      t = SW'(a[i]);
      o = o | (t << (i * w));
    end
    return o;
  endfunction

  function automatic logic [SW-1:0] rnd_blk();
    logic [SW-1:0] v;
    for (int i = 0; i < SW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin : main
    vec_t tv [6];
    logic [SW-1:0] tmp, blk, blk2, exp_blk;
    logic [SW-1:0] expq [$];
    longint last_acc, acc_edge;
    int g, n, issued, done, guard;
    logic acc, seen;
    // rotation offsets from the triangular-number walk over (x,y) -> (y, 2x+3y)
    begin : rho_gen
      int x, y, t2;
      x = 1;
      y = 0;
      rho_off[0] = 0;
      for (int t = 0; t < 24; t++) begin
        rho_off[x + 5*y] = ((t + 1) * (t + 2) / 2) % 64;
        t2 = y;
        y = (2*x + 3*y) % 5;
        x = t2;
      end
    end
    for (int i = 0; i < 2; i++) begin
      s_in_valid[i] = 0;
      s_out_ready[i] = 0;
      s_in_data[i] = '0;
    end
    tv[0] = '{0, 25'h0, 25'h0};
    tv[1] = '{0, 25'h1, 25'h1160F17};
    tv[2] = '{1, 25'h0, 25'h1};
    for (int i = 3; i < 6; i++) begin
      tv[i].sel = (i == 3) ? 0 : 1;
      tv[i].din = 25'($urandom);
      tmp = model(SW'(tv[i].din), 1, tv[i].sel + 1);
      tv[i].exp = tmp[24:0];
    end

    #3;
    chk("reset_in_ready", 64'(in_ready), 1);
    chk("reset_out_valid", 64'(out_valid), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_round_idx", 64'(round_idx), 0);
    tick;
    rst = 1;
    tick;
    chk("post_reset_in_ready", 64'(in_ready), 1);
    chk("post_reset_out_valid", 64'(out_valid), 0);

    for (int i = 0; i < 6; i++) begin
      g = tv[i].sel;
      s_in_valid[g] = 1;
      s_in_data[g] = tv[i].din;
      chk("small_in_ready_idle", 64'(s_in_ready[g]), 1);
      tick;
      s_in_valid[g] = 0;
      s_in_data[g] = 25'($urandom);
      chk("small_busy_after_accept", 64'(s_busy[g]), 1);
      chk("small_out_valid_in_run", 64'(s_out_valid[g]), 0);
      n = 0;
      while (!s_out_valid[g] && n < 20) begin
        tick;
        n++;
      end
      chk("small_latency", 64'(n), 64'(g + 1));
      chk("small_out_data", 64'(s_out_data[g]), 64'(tv[i].exp));
      chk("small_in_ready_done_blocked", 64'(s_in_ready[g]), 0);
      s_out_ready[g] = 1;
      #1;
      chk("small_in_ready_done_open", 64'(s_in_ready[g]), 1);
      tick;
      s_out_ready[g] = 0;
      chk("small_idle_after_take", 64'(s_out_valid[g]), 0);
    end

    // back-to-back stream: throughput, round index sequence, data
    out_ready = 1;
    in_valid = 1;
    in_data = rnd_blk();
    last_acc = -1;
    acc_edge = 0;
    issued = 0;
    done = 0;
    guard = 0;
    while (done < 6 && guard < 2000) begin
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_unexpected_out: out_valid with nothing pending (cycle %0d)", cyc);
        end else chk_blk("stream_data", out_data, expq.pop_front());
        done++;
      end
      if (busy) chk("stream_round_idx", 64'(round_idx), 64'(cyc - acc_edge));
      acc = in_valid && in_ready;
      tick;
      guard++;
      if (acc) begin
        expq.push_back(model(in_data, W, R));
        if (last_acc >= 0) chk("stream_throughput", 64'(cyc - last_acc), 25);
        last_acc = cyc;
        acc_edge = cyc;
        issued++;
        if (issued == 6) in_valid = 0;
        else in_data = rnd_blk();
      end
    end
    chk("stream_blocks_done", 64'(done), 6);
    out_ready = 0;
    tick;

    // accept, then scramble inputs during RUN, then backpressure in DONE
    blk = rnd_blk();
    blk2 = rnd_blk();
    exp_blk = model(blk, W, R);
    in_valid = 1;
    in_data = blk;
    tick;
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid = 1'($urandom);
      in_data = rnd_blk();
      chk("run_in_ready_low", 64'(in_ready), 0);
      tick;
      n++;
    end
    chk("run_latency", 64'(n), 24);
    chk_blk("run_scrambled_data", out_data, exp_blk);
    in_valid = 1;
    in_data = blk2;
    for (int i = 0; i < 5; i++) begin
      chk_blk("hold_out_data", out_data, exp_blk);
      chk("hold_out_valid", 64'(out_valid), 1);
      chk("hold_in_ready", 64'(in_ready), 0);
      tick;
    end
    out_ready = 1;
    #1;
    chk("b2b_in_ready", 64'(in_ready), 1);
    tick;
    out_ready = 0;
    in_valid = 0;
    chk("b2b_busy", 64'(busy), 1);
    chk("b2b_out_valid", 64'(out_valid), 0);
    n = 0;
    while (!out_valid && n < 40) begin
      tick;
      n++;
    end
    chk("b2b_latency", 64'(n), 24);
    chk_blk("b2b_data", out_data, model(blk2, W, R));
    out_ready = 1;
    tick;
    out_ready = 0;

    // asynchronous abort mid-RUN
    in_valid = 1;
    in_data = rnd_blk();
    tick;
    in_valid = 0;
    repeat (5) tick;
    chk("abort_busy_before", 64'(busy), 1);
    #2 rst = 0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_in_ready", 64'(in_ready), 1);
    chk("abort_round_idx", 64'(round_idx), 0);
    #2 rst = 1;
    seen = 0;
    repeat (40) begin
      tick;
      if (out_valid || busy) seen = 1;
    end
    chk("abort_no_result", 64'(seen), 0);
    chk("abort_idle_ready", 64'(in_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
